// File: rtl/pipe_pkg.sv
// Shared payload and control types for the five-stage pipeline's inter-stage registers.
// The MEM/WB bundle is the reference payload for a pipe_reg_elastic instance.
package pipe_pkg;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_ctrl_t;

  // Field order fixes the bit packing seen by the register: wb_ctrl occupies the top bits.
  typedef struct packed {
    wb_ctrl_t    wb;
    logic [31:0] dm_out;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
  } mem_wb_payload_t;

  localparam int MEM_WB_WIDTH = $bits(mem_wb_payload_t);

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the elastic pipeline register: a valid bit plus its payload.
// Data is captured only alongside a valid bit, so a bubble never overwrites held data.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             flush,
  input  logic             prev_v,
  input  logic [WIDTH-1:0] prev_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  // Slot state: reset, then flush, then a load from the previous slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (flush) begin
      r_v <= 1'b0;
      if (CLEAR_ON_FLUSH != 0) begin
        r_d <= '0;
      end
    end else if (load) begin
      r_v <= prev_v;
      if (prev_v) begin
        r_d <= prev_d;
      end
    end
  end

  assign v = r_v;
  assign d = r_d;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH slots with valid/ready handshake, bubble collapsing,
// stall back-pressure, flush and occupancy count. DEPTH=1 with out_ready high is a plain latch.
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter  int WIDTH          = 32,
  parameter  int DEPTH          = 1,
  parameter  int CLEAR_ON_FLUSH = 1,
  localparam int CW             = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d [DEPTH];
  logic [DEPTH-1:0] w_rdy;
  logic [CW-1:0]    w_count;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic             w_prev_v;
    logic [WIDTH-1:0] w_prev_d;

    if (i == 0) begin : g_head
      assign w_prev_v = in_valid;
      assign w_prev_d = in_data;
    end else begin : g_body
      assign w_prev_v = w_v[i-1];
      assign w_prev_d = w_d[i-1];
    end

    // Unrolled ready chain: slot i can move unless it and every slot after it are full
    // while the consumer stalls.
    assign w_rdy[i] = out_ready | ~(&w_v[DEPTH-1:i]);

    pipe_slot #(
      .WIDTH          (WIDTH),
      .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (w_rdy[i]),
      .flush  (flush),
      .prev_v (w_prev_v),
      .prev_d (w_prev_d),
      .v      (w_v[i]),
      .d      (w_d[i])
    );
  end

  // Occupancy is the population count of the slot valid bits.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CW'(w_v[i]);
    end
  end

  assign in_ready  = w_rdy[0] & ~flush & rst;
  assign out_valid = w_v[DEPTH-1] & ~flush;
  assign out_data  = w_d[DEPTH-1];
  assign count     = w_count;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Scoreboard bench for pipe_reg_elastic: a DEPTH=1 MEM/WB instance and a DEPTH=3 instance
// checked by a queue-based reference model under directed and random traffic.
module tb_pipe_reg_elastic;
  import pipe_pkg::*;

  localparam int D3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst1, flush1, iv1, ir1, ov1, or1;
  logic [MEM_WB_WIDTH-1:0] id1, od1;
  logic [0:0]              cnt1;

  logic        rst3, flush3, iv3, ir3, ov3, or3;
  logic [31:0] id3, od3;
  logic [1:0]  cnt3;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] q[$];
  mem_wb_payload_t pay;

  pipe_reg_elastic #(.WIDTH(MEM_WB_WIDTH), .DEPTH(1), .CLEAR_ON_FLUSH(1)) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cnt1)
  );

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(D3), .CLEAR_ON_FLUSH(1)) dut3 (
    .clk(clk), .rst(rst3), .flush(flush3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .count(cnt3)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; sampling happens 8 after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    #6;
  endtask

  // Monitor and reference model: held entries form a FIFO that a flush or reset empties.
  always begin
    logic [31:0] e;
    logic        exp_ir;
    @(posedge clk);
    #8;
    if (!rst3) begin
      q.delete();
      chk("rst_count", 128'(cnt3), 128'd0);
    end else begin
      exp_ir = !flush3 && ((q.size() < D3) || or3);
      chk("in_ready", 128'(ir3), 128'(exp_ir));
      chk("count", 128'(cnt3), 128'(q.size()));
      if (flush3) begin
        chk("flush_out_valid", 128'(ov3), 128'd0);
        q.delete();
      end else begin
        if (ov3 && q.size() == 0) begin
          chk("spurious_out", 128'(ov3), 128'd0);
        end else if (ov3 && or3) begin
          e = q.pop_front();
          chk("out_data", 128'(od3), 128'(e));
        end
        if (iv3 && ir3) begin
          q.push_back(id3);
        end
      end
    end
  end

  initial begin
    rst1 = 1'b0; flush1 = 1'b0; iv1 = 1'b0; or1 = 1'b1; id1 = '0;
    rst3 = 1'b0; flush3 = 1'b0; iv3 = 1'b0; or3 = 1'b0; id3 = 32'd0;
    pay.wb        = 2'b10;
    pay.dm_out    = 32'hDEADBEEF;
    pay.alu_out   = 32'h00000004;
    pay.write_reg = 5'h1F;

    // Reset state
    repeat (3) step();
    smp();
    chk("r1_out_valid", 128'(ov1), 128'd0);
    chk("r1_count", 128'(cnt1), 128'd0);
    chk("r1_out_data", 128'(od1), 128'd0);
    chk("r1_in_ready", 128'(ir1), 128'd0);
    chk("r3_in_ready", 128'(ir3), 128'd0);
    chk("r3_out_valid", 128'(ov3), 128'd0);

    // First transfer through the single-slot MEM/WB register
    step(); rst1 = 1'b1; rst3 = 1'b1; iv1 = 1'b1; id1 = pay;
    smp();
    chk("first_in_ready1", 128'(ir1), 128'd1);
    chk("first_in_ready3", 128'(ir3), 128'd1);
    step(); iv1 = 1'b0;
    smp();
    chk("first_out_valid", 128'(ov1), 128'd1);
    chk("first_out_data", 128'(od1), 128'(pay));
    chk("first_count", 128'(cnt1), 128'd1);
    step();
    smp();
    chk("empty_out_valid", 128'(ov1), 128'd0);
    chk("empty_hold_data", 128'(od1), 128'(pay));
    chk("empty_count", 128'(cnt1), 128'd0);

    // Streaming 1..10 through DEPTH=3
    or3 = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      iv3 = (k < 10);
      id3 = 32'(k + 1);
      smp();
      if (k >= 3) begin
        chk("stream_valid", 128'(ov3), 128'd1);
        chk("stream_data", 128'(od3), 128'(k - 2));
      end
      if (k >= 3 && k <= 10) begin
        chk("stream_count", 128'(cnt3), 128'd3);
      end
    end
    step(); iv3 = 1'b0;
    smp();
    chk("stream_drained", 128'(ov3), 128'd0);

    // Stall and bubble collapse
    step(); iv3 = 1'b1; id3 = 32'd5;
    step(); iv3 = 1'b0;
    step(); iv3 = 1'b1; id3 = 32'd6; or3 = 1'b0;
    step(); iv3 = 1'b0;
    step(); iv3 = 1'b1; id3 = 32'd7;
    smp();
    chk("stall_count2", 128'(cnt3), 128'd2);
    step(); iv3 = 1'b1; id3 = 32'd99;
    smp();
    chk("stall_full_count", 128'(cnt3), 128'd3);
    chk("stall_full_ready", 128'(ir3), 128'd0);
    chk("stall_head", 128'(od3), 128'd5);

    // Full pipeline with a simultaneous in and out transfer
    step(); iv3 = 1'b1; id3 = 32'd8; or3 = 1'b1;
    smp();
    chk("full_conc_ready", 128'(ir3), 128'd1);
    chk("full_conc_out5", 128'(od3), 128'd5);
    step(); iv3 = 1'b0;
    smp();
    chk("full_conc_out6", 128'(od3), 128'd6);
    chk("full_conc_count", 128'(cnt3), 128'd3);
    step(); smp();
    chk("full_conc_out7", 128'(od3), 128'd7);
    step(); smp();
    chk("full_conc_out8", 128'(od3), 128'd8);
    step(); smp();
    chk("full_conc_empty", 128'(ov3), 128'd0);

    // Flush priority over a concurrent input and output
    or3 = 1'b0;
    step(); iv3 = 1'b1; id3 = 32'd11;
    step(); id3 = 32'd12;
    step(); iv3 = 1'b0;
    step(); smp();
    chk("pre_flush_count", 128'(cnt3), 128'd2);
    step(); flush3 = 1'b1; iv3 = 1'b1; id3 = 32'd13; or3 = 1'b1;
    smp();
    chk("flush_valid_now", 128'(ov3), 128'd0);
    chk("flush_ready_now", 128'(ir3), 128'd0);
    step(); flush3 = 1'b0; iv3 = 1'b0;
    smp();
    chk("post_flush_count", 128'(cnt3), 128'd0);
    chk("post_flush_data", 128'(od3), 128'd0);
    repeat (4) step();
    smp();
    chk("flushed_never_out", 128'(ov3), 128'd0);

    // Asynchronous reset between clock edges
    or3 = 1'b0;
    step(); iv3 = 1'b1; id3 = 32'd21;
    step(); id3 = 32'd22;
    step(); iv3 = 1'b0;
    step(); smp();
    chk("pre_rst_count", 128'(cnt3), 128'd2);
    step(); #2; rst3 = 1'b0; #1;
    chk("async_rst_valid", 128'(ov3), 128'd0);
    chk("async_rst_count", 128'(cnt3), 128'd0);
    step(); rst3 = 1'b1;
    smp();
    chk("after_rst_ready", 128'(ir3), 128'd1);

    // Random traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      step();
      iv3    = 1'($urandom_range(0, 1));
      id3    = $urandom;
      or3    = ($urandom_range(0, 3) != 0);
      flush3 = ($urandom_range(0, 24) == 0);
    end
    step(); iv3 = 1'b0; or3 = 1'b1; flush3 = 1'b0;
    repeat (6) step();
    smp();
    chk("drain_queue", 128'(q.size()), 128'd0);
    chk("drain_valid", 128'(ov3), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_reg_elastic.md
# pipe_reg_elastic

Parametrised elastic pipeline register that replaces the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the five-stage MIPS pipeline with one reusable block. It carries an arbitrary-width payload through DEPTH register slots and adds a valid/ready handshake, bubble collapsing, stall back-pressure, flush and occupancy reporting. With DEPTH=1 and out_ready tied high, it reproduces a plain stage latch.

## Interface
- WIDTH, 32: payload width in bits; the instantiating stage packs control and data into one bus (e.g. {wb_ctrl, dm_out, alu_out, write_reg}).
- DEPTH, 1: number of register slots, ≥1.
- CLEAR_ON_FLUSH, 1: 1 zeroes slot data on flush; 0 keeps data and clears only the valid bits.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discards every held entry.
- in_valid  in  1  upstream holds a payload.
- in_ready  out  1  block accepts the payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  slot DEPTH-1 holds a payload.
- out_ready  in  1  downstream accepts; tie low to stall.
- out_data  out  WIDTH  payload in slot DEPTH-1.
- count  out  $clog2(DEPTH+1)  number of valid slots.

## Operation
- Slots 0..DEPTH-1 each hold v[i] and d[i]. Slot 0 is fed from in_data; slot DEPTH-1 drives the outputs.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready
  - rdy[i] = !v[i] | rdy[i+1]
  - in_ready = rdy[0] & !flush & rst
- Slot i loads when rdy[i] is high:
  - v[i] takes the valid bit of the previous slot (or in_valid for slot 0).
  - d[i] takes the previous slot's data, and only when that valid bit is 1; otherwise d[i] is held.
- Bubbles collapse: an empty slot accepts from upstream even when out_ready is low.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Flush:
  - While flush is high, out_valid = 0 and in_ready = 0; no transfer on either side.
  - Next edge: all v = 0, count = 0, and all d = 0 if CLEAR_ON_FLUSH.
  - Flush takes priority over a simultaneous in_valid, out_ready or stall.
- count = popcount(v). It updates with v; no separate counter.
- Reset (rst low, asynchronous):
  - v = 0, d = 0, out_valid = 0, out_data = 0, count = 0, in_ready = 0.
  - After rst rises, in_ready = 1 in the same cycle.
  - Reset mid-stream drops all entries with no partial outputs.

## Timing
- Latency: an accepted payload appears on out_data DEPTH cycles later if unstalled.
- Throughput: one transfer per cycle, sustained, with out_ready held high.
- Full pipeline (count = DEPTH) with out_ready low: in_ready = 0 in the same cycle.
- Full pipeline with out_ready high: in_ready = 1, and a simultaneous in and out transfer leaves count unchanged.
- Empty pipeline: out_valid = 0 and out_data holds its last value (0 after reset or flush when CLEAR_ON_FLUSH).
- Path constraints: in_ready depends combinationally on out_ready and flush. Data path has no combinational in-to-out path for DEPTH ≥ 1.

## Structure
- Shared package pipe_pkg:
  - wb_ctrl_t (2 bits: reg_write, mem_to_reg)
  - mem_ctrl_t
  - ex_ctrl_t
  - mem_wb_payload_t, a packed struct for the MEM/WB instance: WIDTH = 2 + 32 + 32 + 5 = 71.
- Sub-module pipe_slot holds one v/d pair:
  - Inputs: load, flush, prev_v, prev_d.
  - Generated DEPTH times; the top level contains only the ready chain and count.

## Test plan
- Reset and first transfer (DEPTH=1, WIDTH=71):
  - Hold rst low → out_valid = 0, count = 0, out_data = 0, in_ready = 0.
  - Release rst, drive in_data = 71'h0A_DEADBEEF_00000004_1F (hex field grouping illustrative; total width is 71 bits) → out_data equals it one cycle later, out_valid = 1.
- Streaming (DEPTH=3): drive values 1..10 on consecutive cycles with out_ready = 1 → out_data sequence 1..10 starting 3 cycles later, no gaps, count steady at 3.
- Stall and collapse (DEPTH=3):
  - Accept 5, idle one cycle, accept 6, drop out_ready → slots fill to count = 3 without loss, then in_ready = 0.
  - Raise out_ready → 5 then 6 emerge on consecutive cycles.
- Full-pipeline concurrency: count = 3, out_ready = 1, in_valid = 1 → in_ready = 1, count stays 3, order preserved.
- Flush priority:
  - count = 2, assert flush together with in_valid = 1 and out_ready = 1 → out_valid = 0 in the same cycle.
  - Next cycle count = 0, out_data = 0 (CLEAR_ON_FLUSH=1); the flushed input never appears.
- Mid-stream async reset: pull rst low between clock edges with count = 2 → out_valid and count drop to 0 immediately, without waiting for a clock edge.
